pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter STAGES, default 6: pipeline stage count; bit 0 = PC/fetch, bit STAGES-1 = writeback.
REQ-002 Parameter SEL_W, default 3: stage-index width; SHALL satisfy 2^SEL_W >= STAGES.
REQ-003 Parameter CNT_W, default 4: timed-hold cycle-count width.
REQ-004 Parameter WDOG_W, default 8: watchdog counter width.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset (rst==1 is RstEnable).
REQ-007 stallreq_i  input  STAGES  bit i=1: stage i requests a stall this cycle (combinational request).
REQ-008 hold_start_i  input  1  load a timed stall.
REQ-009 hold_stage_i  input  SEL_W  stage that owns the timed stall; values >= STAGES treated as STAGES-1.
REQ-010 hold_cycles_i  input  CNT_W  timed-stall length in cycles.
REQ-011 excp_i  input  1  exception/redirect request.
REQ-012 excp_pc_i  input  32  redirect target.
REQ-013 stall_o  output  STAGES  per-stage freeze vector.
REQ-014 flush_o  output  1  registered flush pulse.
REQ-015 new_pc_o  output  32  registered redirect target, valid while flush_o=1.
REQ-016 hold_busy_o  output  1  timed stall active.
REQ-017 timeout_o  output  1  sticky watchdog flag.
REQ-018 stall_cnt_o  output  32  total stalled-cycle count.

Function
REQ-019 Effective request set = stallreq_i OR (one-hot of hold_stage when hold counter != 0).
REQ-020 h = highest asserted index of the effective set; stall_o SHALL be bits 0..h set, others clear (h=3 -> 6'b001111, h=2 -> 6'b000111); empty set -> all zero.
REQ-021 stall_o SHALL be combinational from current requests and registered state; zero-latency.
REQ-022 While flush_o=1, stall_o SHALL be all zero regardless of requests.
REQ-023 excp_i=1 at cycle t -> flush_o=1 and new_pc_o=excp_pc_i at cycle t+1, for exactly one cycle unless excp_i=1 again at t+1.
REQ-024 excp_i at cycle t SHALL clear the hold counter at the t edge; hold_start_i in the same cycle SHALL be ignored.
REQ-025 hold_start_i=1 with hold_cycles_i=n>0 at cycle t (no excp_i) -> hold counter=n; hold active cycles t+1..t+n, counter decrements by 1 per cycle, stops at 0.
REQ-026 hold_cycles_i=0 with hold_start_i=1 SHALL be ignored; existing hold unaffected.
REQ-027 hold_start_i while hold active SHALL reload counter and stage (restart, no accumulation).
REQ-028 hold_busy_o = (hold counter != 0).
REQ-029 Watchdog counter SHALL increment each cycle stall_o[0]=1, clear to 0 on any cycle stall_o[0]=0, saturate at 2^WDOG_W-1.
REQ-030 timeout_o SHALL set on the edge where watchdog reaches 2^WDOG_W-1 and stay set until reset.
REQ-031 stall_cnt_o SHALL increment each cycle stall_o[0]=1 and saturate at 0xFFFFFFFF.
REQ-032 new_pc_o SHALL hold its last value when flush_o=0.

Reset
REQ-033 rst=1 at an edge SHALL clear hold counter, hold stage, flush_o, new_pc_o, watchdog, timeout_o, stall_cnt_o to 0.
REQ-034 While rst=1, stall_o SHALL be all zero (combinational override), independent of inputs.
REQ-035 Reset SHALL override excp_i and hold_start_i in the same cycle; mid-hold reset aborts the hold.

Verification
REQ-036 STAGES=6; stallreq_i=6'b000100 -> stall_o=6'b000111; stallreq_i=6'b001100 -> 6'b001111; 0 -> 0.
REQ-037 hold_start=1, stage=4, cycles=3 at t -> stall_o=6'b011111 and hold_busy_o=1 at t+1..t+3, both clear at t+4.
REQ-038 Hold active, excp_i=1, excp_pc_i=0xBFC00380 at t -> t+1: flush_o=1, new_pc_o=0xBFC00380, stall_o=0, hold_busy_o=0; t+2: flush_o=0.
REQ-039 WDOG_W=4, stallreq_i[1]=1 held 20 cycles -> timeout_o rises after 15th stalled cycle, stays 1 after request drops; stall_cnt_o=20.
REQ-040 rst=1 asserted mid-hold with excp_i=1 -> next cycle all outputs 0, no flush pulse after rst deasserts.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - Pipeline stall/flush controller with timed holds, watchdog and stall counter.
module pipe_stall_ctrl #(
    parameter int STAGES = 6,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 4,
    parameter int WDOG_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic              hold_start_i,
    input  logic [SEL_W-1:0]  hold_stage_i,
    input  logic [CNT_W-1:0]  hold_cycles_i,
    input  logic              excp_i,
    input  logic [31:0]       excp_pc_i,
    output logic [STAGES-1:0] stall_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic              hold_busy_o,
    output logic              timeout_o,
    output logic [31:0]       stall_cnt_o
);

    localparam logic [SEL_W-1:0]  LAST_STAGE = SEL_W'(STAGES - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX   = '1;

    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0]  hold_stage_q, hold_stage_d;
    logic              flush_q, flush_d;
    logic [31:0]       new_pc_q, new_pc_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic [STAGES-1:0] eff_req;
    logic [STAGES-1:0] stall_v;

    // A stall at stage h must also freeze every older stage below it.
    always_comb begin
        eff_req = stallreq_i;
        if (hold_cnt_q != '0) begin
            eff_req = eff_req | (STAGES'(1) << hold_stage_q);
        end
        stall_v = '0;
        for (int i = 0; i < STAGES; i++) begin
            stall_v[i] = |(eff_req >> i);
        end
        if (rst || flush_q) begin
            stall_v = '0;
        end
    end

    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        hold_stage_d = hold_stage_q;
        if (excp_i) begin
            hold_cnt_d = '0;
        end else if (hold_start_i && (hold_cycles_i != '0)) begin
            hold_cnt_d   = hold_cycles_i;
            hold_stage_d = (hold_stage_i > LAST_STAGE) ? LAST_STAGE : hold_stage_i;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end

        flush_d  = excp_i;
        new_pc_d = excp_i ? excp_pc_i : new_pc_q;

        if (stall_v[0]) begin
            wdog_d      = (wdog_q == WDOG_MAX) ? WDOG_MAX : wdog_q + WDOG_W'(1);
            stall_cnt_d = (stall_cnt_q == 32'hFFFF_FFFF) ? stall_cnt_q : stall_cnt_q + 32'd1;
        end else begin
            wdog_d      = '0;
            stall_cnt_d = stall_cnt_q;
        end
        timeout_d = timeout_q | (wdog_d == WDOG_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q   <= '0;
            hold_stage_q <= '0;
            flush_q      <= 1'b0;
            new_pc_q     <= '0;
            wdog_q       <= '0;
            timeout_q    <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            hold_stage_q <= hold_stage_d;
            flush_q      <= flush_d;
            new_pc_q     <= new_pc_d;
            wdog_q       <= wdog_d;
            timeout_q    <= timeout_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign stall_o     = stall_v;
    assign flush_o     = flush_q;
    assign new_pc_o    = new_pc_q;
    assign hold_busy_o = (hold_cnt_q != '0);
    assign timeout_o   = timeout_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - Self-checking bench for pipe_stall_ctrl against a behavioural model.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stallreq_i;
    logic        hold_start_i;
    logic [2:0]  hold_stage_i;
    logic [3:0]  hold_cycles_i;
    logic        excp_i;
    logic [31:0] excp_pc_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        hold_busy_o;
    logic        timeout_o;
    logic [31:0] stall_cnt_o;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int      m_hold;
    int      m_stage;
    bit      m_flush;
    int unsigned m_pc;
    int      m_wdog;
    bit      m_timeout;
    longint  m_cnt;

    pipe_stall_ctrl #(.STAGES(6), .SEL_W(3), .CNT_W(4), .WDOG_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_i   (stallreq_i),
        .hold_start_i (hold_start_i),
        .hold_stage_i (hold_stage_i),
        .hold_cycles_i(hold_cycles_i),
        .excp_i       (excp_i),
        .excp_pc_i    (excp_pc_i),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .new_pc_o     (new_pc_o),
        .hold_busy_o  (hold_busy_o),
        .timeout_o    (timeout_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] exp_stall();
        int eff;
        int h;
        eff = int'(stallreq_i);
        if (m_hold > 0) eff = eff | (1 << m_stage);
        if (rst || m_flush || eff == 0) return 6'd0;
        h = $clog2(eff + 1) - 1;
        return 6'((1 << (h + 1)) - 1);
    endfunction

    task automatic tick();
        logic [5:0] s;
        int n_hold, n_stage, n_wdog;
        bit n_flush, n_timeout;
        int unsigned n_pc;
        longint n_cnt;
        s = exp_stall();
        if (rst) begin
            n_hold = 0; n_stage = 0; n_flush = 0; n_pc = 0;
            n_wdog = 0; n_timeout = 0; n_cnt = 0;
        end else begin
            n_stage = m_stage;
            if (excp_i) n_hold = 0;
            else if (hold_start_i && hold_cycles_i != 0) begin
                n_hold  = int'(hold_cycles_i);
                n_stage = (int'(hold_stage_i) > 5) ? 5 : int'(hold_stage_i);
            end else n_hold = (m_hold > 0) ? m_hold - 1 : 0;
            n_flush = excp_i;
            n_pc    = excp_i ? excp_pc_i : m_pc;
            if (s[0]) begin
                n_wdog = (m_wdog + 1 > 15) ? 15 : m_wdog + 1;
                n_cnt  = (m_cnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
            end else begin
                n_wdog = 0;
                n_cnt  = m_cnt;
            end
            n_timeout = m_timeout || (n_wdog == 15);
        end
        @(posedge clk);
        #1;
        m_hold = n_hold; m_stage = n_stage; m_flush = n_flush; m_pc = n_pc;
        m_wdog = n_wdog; m_timeout = n_timeout; m_cnt = n_cnt;
    endtask

    task automatic idle_inputs();
        stallreq_i = '0; hold_start_i = 0; hold_stage_i = '0;
        hold_cycles_i = '0; excp_i = 0; excp_pc_i = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; stallreq_i = 6'b101010; excp_i = 1; excp_pc_i = 32'h1234_5678;
        hold_start_i = 1; hold_cycles_i = 4'd5;
        #1;
        checks++;
        if (stall_o !== 6'd0) begin errors++; $display("FAIL reset_stall got=%b exp=000000", stall_o); end
        tick();
        tick();
        checks++;
        if ({flush_o, hold_busy_o, timeout_o} !== 3'b000 || new_pc_o !== 32'd0 || stall_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs got flush=%b busy=%b to=%b pc=%h cnt=%0d exp all zero",
                     flush_o, hold_busy_o, timeout_o, new_pc_o, stall_cnt_o);
        end
        idle_inputs();
        rst = 0;
        tick();
    endtask

    task automatic test_comb_stall();
        logic [5:0] reqs [3] = '{6'b000100, 6'b001100, 6'b000000};
        logic [5:0] exps [3] = '{6'b000111, 6'b001111, 6'b000000};
        for (int i = 0; i < 3; i++) begin
            stallreq_i = reqs[i];
            #1;
            checks++;
            if (stall_o !== exps[i]) begin
                errors++; $display("FAIL comb_stall[%0d] got=%b exp=%b", i, stall_o, exps[i]);
            end
        end
        tick();
    endtask

    task automatic test_hold();
        stallreq_i = '0; hold_start_i = 1; hold_stage_i = 3'd4; hold_cycles_i = 4'd3;
        tick();
        hold_start_i = 0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++;
            if (stall_o !== 6'b011111 || hold_busy_o !== 1'b1) begin
                errors++; $display("FAIL hold_t%0d got stall=%b busy=%b exp 011111/1", k, stall_o, hold_busy_o);
            end
            tick();
        end
        checks++;
        if (stall_o !== 6'b000000 || hold_busy_o !== 1'b0) begin
            errors++; $display("FAIL hold_end got stall=%b busy=%b exp 000000/0", stall_o, hold_busy_o);
        end
    endtask

    task automatic test_excp_during_hold();
        hold_start_i = 1; hold_stage_i = 3'd2; hold_cycles_i = 4'd5;
        tick();
        hold_start_i = 0; excp_i = 1; excp_pc_i = 32'hBFC0_0380;
        tick();
        excp_i = 0; stallreq_i = 6'b001000;
        #1;
        checks++;
        if (flush_o !== 1'b1 || new_pc_o !== 32'hBFC0_0380 || stall_o !== 6'd0 || hold_busy_o !== 1'b0) begin
            errors++; $display("FAIL excp_t1 got flush=%b pc=%h stall=%b busy=%b exp 1/bfc00380/000000/0",
                               flush_o, new_pc_o, stall_o, hold_busy_o);
        end
        tick();
        checks++;
        if (flush_o !== 1'b0 || new_pc_o !== 32'hBFC0_0380 || stall_o !== 6'b001111) begin
            errors++; $display("FAIL excp_t2 got flush=%b pc=%h stall=%b exp 0/bfc00380/001111",
                               flush_o, new_pc_o, stall_o);
        end
        stallreq_i = '0;
        tick();
    endtask

    task automatic test_watchdog();
        rst = 1; tick(); rst = 0;
        stallreq_i = 6'b000010;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                checks++;
                if (timeout_o !== 1'b0) begin errors++; $display("FAIL wdog_early got=%b exp=0", timeout_o); end
            end
            if (i == 15) begin
                checks++;
                if (timeout_o !== 1'b1) begin errors++; $display("FAIL wdog_rise got=%b exp=1", timeout_o); end
            end
        end
        stallreq_i = '0;
        tick();
        tick();
        checks++;
        if (timeout_o !== 1'b1 || stall_cnt_o !== 32'd20) begin
            errors++; $display("FAIL wdog_sticky got to=%b cnt=%0d exp 1/20", timeout_o, stall_cnt_o);
        end
    endtask

    task automatic test_reset_mid_hold();
        hold_start_i = 1; hold_stage_i = 3'd3; hold_cycles_i = 4'd6;
        tick();
        rst = 1; excp_i = 1; excp_pc_i = 32'h0000_0123; hold_cycles_i = 4'd4;
        #1;
        checks++;
        if (stall_o !== 6'd0) begin errors++; $display("FAIL rstmid_comb got=%b exp=000000", stall_o); end
        tick();
        rst = 0; excp_i = 0; hold_start_i = 0;
        #1;
        checks++;
        if (flush_o !== 1'b0 || hold_busy_o !== 1'b0 || stall_o !== 6'd0 || new_pc_o !== 32'd0 ||
            timeout_o !== 1'b0 || stall_cnt_o !== 32'd0) begin
            errors++; $display("FAIL rstmid_regs got flush=%b busy=%b stall=%b pc=%h to=%b cnt=%0d exp all zero",
                               flush_o, hold_busy_o, stall_o, new_pc_o, timeout_o, stall_cnt_o);
        end
        tick();
        checks++;
        if (flush_o !== 1'b0 || hold_busy_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_after got flush=%b busy=%b exp 0/0", flush_o, hold_busy_o);
        end
    endtask

    task automatic test_random();
        logic [5:0] es;
        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 39) == 0);
            stallreq_i    = 6'($urandom) & 6'($urandom) & 6'($urandom);
            hold_start_i  = ($urandom_range(0, 5) == 0);
            hold_stage_i  = 3'($urandom);
            hold_cycles_i = 4'($urandom_range(0, 6));
            excp_i        = ($urandom_range(0, 11) == 0);
            excp_pc_i     = $urandom;
            #1;
            es = exp_stall();
            checks++;
            if (stall_o !== es) begin errors++; $display("FAIL rand_stall[%0d] got=%b exp=%b", n, stall_o, es); end
            tick();
            checks++;
            if (flush_o !== m_flush || new_pc_o !== m_pc || hold_busy_o !== (m_hold > 0) ||
                timeout_o !== m_timeout || stall_cnt_o !== 32'(m_cnt)) begin
                errors++;
                $display("FAIL rand_regs[%0d] got flush=%b pc=%h busy=%b to=%b cnt=%0d exp %b/%h/%b/%b/%0d",
                         n, flush_o, new_pc_o, hold_busy_o, timeout_o, stall_cnt_o,
                         m_flush, m_pc, (m_hold > 0), m_timeout, m_cnt);
            end
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        m_hold = 0; m_stage = 0; m_flush = 0; m_pc = 0; m_wdog = 0; m_timeout = 0; m_cnt = 0;
        test_reset();
        test_comb_stall();
        test_hold();
        test_excp_during_hold();
        test_watchdog();
        test_reset_mid_hold();
        rst = 1; idle_inputs(); tick(); rst = 0;
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
